// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready handshake.
// Single-cycle ops register in one cycle; multu/divu iterate one bit per cycle into HI/LO.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  state_t r_state;
  state_t w_next;

  logic               r_out_valid;
  logic               r_illegal;
  logic               r_zero;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_cnt;

  logic               w_accept;
  logic [WIDTH-1:0]   w_res;
  logic               w_ill;
  logic               w_mul;
  logic               w_div;
  logic               w_slt;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mstep;
  logic [WIDTH:0]     w_rsh;
  logic               w_rge;
  logic [WIDTH-1:0]   w_rsub;
  logic [2*WIDTH-1:0] w_dstep;
  logic [2*WIDTH-1:0] w_step;
  logic               w_last;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;
  assign result    = r_result;
  assign zero      = r_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign w_slt     = $signed(a) < $signed(b);

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    w_mul = 1'b0;
    w_div = 1'b0;
    unique case (alu_op)
      2'b00: w_res = a + b;
      2'b01: w_res = a - b;
      2'b11: w_res = a & b;
      default: begin
        unique case (funct)
          F_ADD:   w_res = a + b;
          F_SUB:   w_res = a - b;
          F_AND:   w_res = a & b;
          F_OR:    w_res = a | b;
          F_NOR:   w_res = ~(a | b);
          F_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_slt};
          F_SLL:   w_res = b << shamt;
          F_SRL:   w_res = b >> shamt;
          F_JR:    w_res = a;
          F_MFHI:  w_res = r_hi;
          F_MFLO:  w_res = r_lo;
          F_MULTU: w_mul = 1'b1;
          F_DIVU:  w_div = 1'b1;
          default: w_ill = 1'b1;
        endcase
      end
    endcase
  end

  // Shift-add: upper half accumulates multiplicand, multiplier drains from lsb
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mstep = {w_msum, r_acc[WIDTH-1:1]};

  // Restoring divide: {rem, quotient/dividend} shifts left one bit per step
  assign w_rsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_rge   = w_rsh >= {1'b0, r_opnd};
  assign w_rsub  = w_rsh[WIDTH-1:0] - r_opnd;
  assign w_dstep = {(w_rge ? w_rsub : w_rsh[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_rge};

  assign w_step = (r_state == S_DIV) ? w_dstep : w_mstep;
  assign w_last = (r_cnt == SHW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_mul) begin
          w_next = S_MUL;
        end else if (w_accept && w_div) begin
          w_next = S_DIV;
        end
      end
      default: begin
        if (w_last) begin
          w_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_zero      <= 1'b1;
      r_result    <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept && (w_mul || w_div)) begin
          r_cnt  <= '0;
          r_opnd <= w_mul ? a : b;
          r_acc  <= {{WIDTH{1'b0}}, (w_mul ? b : a)};
        end else if (w_accept) begin
          r_result    <= w_res;
          r_zero      <= (w_res == '0);
          r_illegal   <= w_ill;
          r_out_valid <= 1'b1;
        end
      end else begin
        r_acc <= w_step;
        r_cnt <= r_cnt + SHW'(1);
        if (w_last) begin
          r_cnt       <= '0;
          r_hi        <= w_step[2*WIDTH-1:WIDTH];
          r_lo        <= w_step[WIDTH-1:0];
          r_result    <= w_step[WIDTH-1:0];
          r_zero      <= (w_step[WIDTH-1:0] == '0);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: behavioural model with per-cycle compare,
// directed literal checks, random stimulus, and a WIDTH=8 instance.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   alu_op = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   shamt = '0;
  logic         in_ready, out_valid, zero, illegal;
  logic [W-1:0] result, hi, lo;

  logic         v8 = 1'b0;
  logic [5:0]   f8 = '0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic [2:0]   sh8 = '0;
  logic         ir8, ov8, z8, il8;
  logic [7:0]   res8, hi8, lo8;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .zero(zero),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  alu_exec_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
    .alu_op(2'b10), .funct(f8), .a(a8), .b(b8), .shamt(sh8),
    .out_valid(ov8), .result(res8), .zero(z8),
    .illegal(il8), .hi(hi8), .lo(lo8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction per accept, mul/div resolved
  // with native arithmetic and released after WIDTH busy cycles.
  int         m_busy = 0;
  bit         m_acc = 0;
  bit         m_rdy = 1;
  bit         m_valid = 0;
  bit         m_ill = 0;
  bit         m_zero = 1;
  logic [W-1:0] m_res = '0, m_hi = '0, m_lo = '0;
  logic [W-1:0] p_hi = '0, p_lo = '0;

  task automatic model_op();
    logic [W-1:0]   r;
    logic [2*W-1:0] prod;
    bit             il;
    r  = '0;
    il = 0;
    case (alu_op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd3: r = a & b;
      default:
        case (funct)
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h27: r = ~(a | b);
          6'h2a: r = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h00: r = b << shamt;
          6'h02: r = b >> shamt;
          6'h08: r = a;
          6'h10: r = m_hi;
          6'h12: r = m_lo;
          6'h19: begin
            prod = {32'h0, a} * {32'h0, b};
            p_hi = prod[2*W-1:W];
            p_lo = prod[W-1:0];
            m_busy = W;
          end
          6'h1b: begin
            p_lo = (b == 0) ? '1 : a / b;
            p_hi = (b == 0) ? a : a % b;
            m_busy = W;
          end
          default: il = 1;
        endcase
    endcase
    if (m_busy == 0) begin
      m_res   = r;
      m_zero  = (r == 0);
      m_ill   = il;
      m_valid = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_valid = 0; m_ill = 0;
      m_res = '0; m_zero = 1; m_hi = '0; m_lo = '0;
    end else begin
      m_rdy   = (m_busy == 0);
      m_valid = 0;
      m_ill   = 0;
      m_acc   = m_rdy && in_valid;
      if (!m_rdy) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_res = p_lo;
          m_zero = (p_lo == 0); m_valid = 1;
        end
      end else if (in_valid) begin
        model_op();
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  W'(in_ready),  W'(m_busy == 0));
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("illegal",   W'(illegal),   W'(m_ill));
    chk("result",    result,        m_res);
    chk("zero",      W'(zero),      W'(m_zero));
    chk("hi",        hi,            m_hi);
    chk("lo",        lo,            m_lo);
  end

  // Present an op and hold it until the model reports acceptance.
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [4:0] sa, output int cyc);
    in_valid = 1; alu_op = op; funct = fn; a = va; b = vb; shamt = sa;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!m_acc && cyc < 200);
    in_valid = 0;
    if (!m_acc) chk("send_timeout", W'(cyc), 0);
  endtask

  task automatic wait_ov(output int k, output int low);
    k = 0; low = 0;
    while (!out_valid && k < 100) begin
      if (!in_ready) low++;
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      5: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] flist [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a,
                             6'h00, 6'h02, 6'h08, 6'h10, 6'h12,
                             6'h19, 6'h1b};

  initial begin
    int c, k, low;
    logic [1:0] op;
    logic [5:0] fn;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset in the middle of a multu
    send(2'b10, 6'h19, 32'd5, 32'd6, 0, c);
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_ready", W'(in_ready), 1);
    chk("rst_ov", W'(out_valid), 0);
    send(2'b00, 6'h00, 32'd3, 32'd4, 0, c);
    chk("rst_add", result, 32'd7);
    chk("rst_add_ov", W'(out_valid), 1);

    // Back-to-back single-cycle ops
    send(2'b00, 6'h00, 32'hffff_ffff, 32'd1, 0, c);
    chk("add_wrap", result, 0);
    chk("add_zero", W'(zero), 1);
    send(2'b01, 6'h00, 32'd5, 32'd5, 0, c);
    chk("sub_zero", W'(zero), 1);
    chk("b2b_cyc", W'(c), 1);
    send(2'b10, 6'h2a, 32'hffff_ffff, 32'd1, 0, c);
    chk("slt", result, 1);
    send(2'b10, 6'h00, 32'd0, 32'd1, 5'd31, c);
    chk("sll", result, 32'h8000_0000);
    send(2'b10, 6'h27, 32'd0, 32'd0, 0, c);
    chk("nor", result, 32'hffff_ffff);
    chk("b2b_cyc2", W'(c), 1);

    // multu max*max, then mfhi in the completion cycle
    send(2'b10, 6'h19, 32'hffff_ffff, 32'hffff_ffff, 0, c);
    wait_ov(k, low);
    chk("mul_lat", W'(k), 32);
    chk("mul_busy", W'(low), 32);
    chk("mul_hi", hi, 32'hffff_fffe);
    chk("mul_lo", lo, 32'h0000_0001);
    chk("mul_res", result, 32'h0000_0001);
    send(2'b10, 6'h10, 0, 0, 0, c);
    chk("mfhi", result, 32'hffff_fffe);

    // divu with an add held through the busy window
    send(2'b10, 6'h1b, 32'd100, 32'd7, 0, c);
    chk("div_res_pre", W'(out_valid), 0);
    send(2'b00, 6'h00, 32'd10, 32'd20, 0, c);
    chk("held_cyc", W'(c), 33);
    chk("div_lo", lo, 32'd14);
    chk("div_hi", hi, 32'd2);
    chk("held_add", result, 32'd30);
    send(2'b10, 6'h1b, 32'd9, 32'd0, 0, c);
    wait_ov(k, low);
    chk("div0_lat", W'(k), 32);
    chk("div0_lo", lo, 32'hffff_ffff);
    chk("div0_hi", hi, 32'd9);
    chk("div0_ill", W'(illegal), 0);

    // Undecoded funct
    send(2'b10, 6'h3f, 32'd1, 32'd2, 0, c);
    chk("ill_res", result, 0);
    chk("ill_flag", W'(illegal), 1);
    chk("ill_ov", W'(out_valid), 1);
    chk("ill_hi", hi, 32'd9);
    @(negedge clk);
    chk("ill_pulse", W'(illegal), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                       : flist[$urandom_range(0, 12)];
      send(op, fn, rnd_val(), rnd_val(), 5'($urandom), c);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    // WIDTH=8 instance
    begin
      logic [5:0] fs [3] = '{6'h19, 6'h1b, 6'h1b};
      logic [7:0] as [3] = '{8'd255, 8'd200, 8'd9};
      logic [7:0] bs [3] = '{8'd255, 8'd7, 8'd0};
      logic [7:0] eh [3] = '{8'hfe, 8'd4, 8'd9};
      logic [7:0] el [3] = '{8'h01, 8'd28, 8'hff};
      for (int t = 0; t < 3; t++) begin
        chk("w8_ready", W'(ir8), 1);
        v8 = 1; f8 = fs[t]; a8 = as[t]; b8 = bs[t];
        @(negedge clk);
        v8 = 0;
        k = 0; low = 0;
        while (!ov8 && k < 50) begin
          if (!ir8) low++;
          @(negedge clk);
          k++;
        end
        chk("w8_lat", W'(k), 8);
        chk("w8_busy", W'(low), 8);
        chk("w8_hi", W'(hi8), W'(eh[t]));
        chk("w8_lo", W'(lo8), W'(el[t]));
        chk("w8_res", W'(res8), W'(el[t]));
        chk("w8_ill", W'(il8), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
